// File: rtl/dpram_fifo_ctrl.sv
// -----------------------------------------------------------------------------
// dpram_fifo_ctrl
// Sequences a simple dual-port RAM (ip_dpram, DEPTH x DATA_W) as a synchronous
// FIFO. Owns the RAM write/read addresses, the write enable and occupancy.
//
// Ports:
//   clock          system clock, rising edge
//   rst_n          synchronous active-low reset
//   wr_req/wr_data producer write request and data
//   rd_req         consumer read request
//   rd_data        read data, valid while rd_valid=1
//   rd_valid       one-cycle strobe for rd_data
//   full/empty     occupancy flags
//   usedw          occupancy 0..DEPTH
//   ovf_err        sticky overflow flag (optional)
//   unf_err        sticky underflow flag (optional)
//   ram_*          connections to ip_dpram (data, wraddress, rdaddress, wren, q)
//
// Optional feature macro: DPRAM_FIFO_ERR_FLAG_EN enables the sticky
// ovf_err/unf_err flags; when undefined both outputs are tied to 0.
// -----------------------------------------------------------------------------
module dpram_fifo_ctrl #(
    parameter int DATA_W     = 8,
    parameter int ADDR_W     = 8,
    parameter int RAM_RD_LAT = 1
) (
    input  logic              clock,
    input  logic              rst_n,
    input  logic              wr_req,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_req,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   usedw,
    output logic              ovf_err,
    output logic              unf_err,
    output logic [DATA_W-1:0] ram_data,
    output logic [ADDR_W-1:0] ram_wraddress,
    output logic [ADDR_W-1:0] ram_rdaddress,
    output logic              ram_wren,
    input  logic [DATA_W-1:0] ram_q
);

    localparam logic [ADDR_W:0]   DEPTH_C   = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0]   CNT_ONE   = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]   CNT_ZERO  = {(ADDR_W+1){1'b0}};
    localparam logic [ADDR_W-1:0] PTR_ONE   = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] PTR_ZERO  = {ADDR_W{1'b0}};
    localparam logic [DATA_W-1:0] DATA_ZERO = {DATA_W{1'b0}};

    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   count;       // true occupancy, drives full/usedw
    logic [ADDR_W:0]   rd_count;    // committed words, drives empty
    logic [ADDR_W:0]   count_next;
    logic [ADDR_W:0]   rd_count_next;
    logic              wr_commit;   // a write accepted last edge lands in RAM this edge
    logic [RAM_RD_LAT:0] vpipe;     // read-valid shift register
    logic [DATA_W-1:0] q_reg;       // registered ram_q
    logic              wr_acc;
    logic              rd_acc;

    assign wr_acc        = wr_req & ~full;
    assign rd_acc        = rd_req & ~empty;
    assign usedw         = count;
    assign ram_rdaddress = rd_ptr;

    // Next-state occupancy for the write side and the committed read side.
    always_comb begin
        count_next    = count;
        rd_count_next = rd_count;
        case ({wr_acc, rd_acc})
            2'b10:   count_next = count + CNT_ONE;
            2'b01:   count_next = count - CNT_ONE;
            default: count_next = count;
        endcase
        // The read side only sees a word once its RAM write edge has passed.
        case ({wr_commit, rd_acc})
            2'b10:   rd_count_next = rd_count + CNT_ONE;
            2'b01:   rd_count_next = rd_count - CNT_ONE;
            default: rd_count_next = rd_count;
        endcase
    end

    // Pointers, occupancy, flags and RAM write port registers.
    always_ff @(posedge clock) begin
        if (!rst_n) begin
            wr_ptr        <= PTR_ZERO;
            rd_ptr        <= PTR_ZERO;
            count         <= CNT_ZERO;
            rd_count      <= CNT_ZERO;
            wr_commit     <= 1'b0;
            full          <= 1'b0;
            empty         <= 1'b1;
            ram_wren      <= 1'b0;
            ram_data      <= DATA_ZERO;
            ram_wraddress <= PTR_ZERO;
        end else begin
            count     <= count_next;
            rd_count  <= rd_count_next;
            wr_commit <= wr_acc;
            full      <= (count_next == DEPTH_C);
            empty     <= (rd_count_next == CNT_ZERO);
            ram_wren  <= wr_acc;
            if (wr_acc) begin
                ram_data      <= wr_data;
                ram_wraddress <= wr_ptr;
                wr_ptr        <= wr_ptr + PTR_ONE;
            end else begin
                ram_data      <= ram_data;
                ram_wraddress <= ram_wraddress;
                wr_ptr        <= wr_ptr;
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end else begin
                rd_ptr <= rd_ptr;
            end
        end
    end

    // Read return path: q is captured every clock, and handed to rd_data when
    // the matching valid bit reaches the end of the pipeline (LAT+1 clocks).
    always_ff @(posedge clock) begin
        if (!rst_n) begin
            vpipe    <= {(RAM_RD_LAT+1){1'b0}};
            q_reg    <= DATA_ZERO;
            rd_valid <= 1'b0;
            rd_data  <= DATA_ZERO;
        end else begin
            vpipe    <= {vpipe[RAM_RD_LAT-1:0], rd_acc};
            q_reg    <= ram_q;
            rd_valid <= vpipe[RAM_RD_LAT];
            if (vpipe[RAM_RD_LAT]) begin
                rd_data <= q_reg;
            end else begin
                rd_data <= rd_data;
            end
        end
    end

`ifdef DPRAM_FIFO_ERR_FLAG_EN
    // Sticky misuse flags, cleared only by reset.
    always_ff @(posedge clock) begin
        if (!rst_n) begin
            ovf_err <= 1'b0;
            unf_err <= 1'b0;
        end else begin
            ovf_err <= ovf_err | (wr_req & full);
            unf_err <= unf_err | (rd_req & empty);
        end
    end
`else
    assign ovf_err = 1'b0;
    assign unf_err = 1'b0;
`endif

endmodule

// File: tb/tb_dpram_fifo_ctrl.sv
// -----------------------------------------------------------------------------
// tb_dpram_fifo_ctrl
// Directed testbench for dpram_fifo_ctrl with a behavioural 1-clock-latency
// RAM beside it. Each scenario task drives stimulus and checks inline.
// -----------------------------------------------------------------------------
module tb_dpram_fifo_ctrl;

    logic       clock = 1'b0;
    logic       rst_n;
    logic       wr_req;
    logic [7:0] wr_data;
    logic       rd_req;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       full;
    logic       empty;
    logic [8:0] usedw;
    logic       ovf_err;
    logic       unf_err;
    logic [7:0] ram_data;
    logic [7:0] ram_wraddress;
    logic [7:0] ram_rdaddress;
    logic       ram_wren;
    logic [7:0] ram_q;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0] mem [0:255];
    logic [7:0] got [$];
    logic [7:0] exp_q [$];

`ifdef DPRAM_FIFO_ERR_FLAG_EN
    localparam logic ERR_EXP = 1'b1;
`else
    localparam logic ERR_EXP = 1'b0;
`endif

    dpram_fifo_ctrl #(.DATA_W(8), .ADDR_W(8), .RAM_RD_LAT(1)) dut (
        .clock(clock), .rst_n(rst_n),
        .wr_req(wr_req), .wr_data(wr_data), .rd_req(rd_req),
        .rd_data(rd_data), .rd_valid(rd_valid),
        .full(full), .empty(empty), .usedw(usedw),
        .ovf_err(ovf_err), .unf_err(unf_err),
        .ram_data(ram_data), .ram_wraddress(ram_wraddress),
        .ram_rdaddress(ram_rdaddress), .ram_wren(ram_wren), .ram_q(ram_q)
    );

    always #5 clock = ~clock;

    // Behavioural ip_dpram: registered write, 1-clock read latency.
    always @(posedge clock) begin
        if (ram_wren) mem[ram_wraddress] <= ram_data;
        ram_q <= mem[ram_rdaddress];
    end

    // Collect every read strobe away from the active edge.
    always @(negedge clock) begin
        if (rd_valid === 1'b1) got.push_back(rd_data);
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; wr_req = 1'b0; rd_req = 1'b0; wr_data = 8'h00;
        tick(); tick();
        rst_n = 1'b1;
        got.delete(); exp_q.delete();
    endtask

    task automatic check_stream(input string name);
        vectors++;
        if (got.size() !== exp_q.size()) begin
            miscompares++;
            $display("FAIL %s count: got %0d pulses, expected %0d", name, got.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                vectors++;
                if (got[i] !== exp_q[i]) begin
                    miscompares++;
                    $display("FAIL %s word %0d: got %02h, expected %02h", name, i, got[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        vectors++; if (empty !== 1'b1) begin miscompares++; $display("FAIL reset empty: got %b, expected 1", empty); end
        vectors++; if (full !== 1'b0) begin miscompares++; $display("FAIL reset full: got %b, expected 0", full); end
        vectors++; if (usedw !== 9'd0) begin miscompares++; $display("FAIL reset usedw: got %0d, expected 0", usedw); end
        vectors++; if (rd_valid !== 1'b0) begin miscompares++; $display("FAIL reset rd_valid: got %b, expected 0", rd_valid); end
        vectors++; if (rd_data !== 8'h00) begin miscompares++; $display("FAIL reset rd_data: got %02h, expected 00", rd_data); end
        vectors++; if (ram_wren !== 1'b0) begin miscompares++; $display("FAIL reset ram_wren: got %b, expected 0", ram_wren); end
        vectors++; if (ram_data !== 8'h00) begin miscompares++; $display("FAIL reset ram_data: got %02h, expected 00", ram_data); end
        vectors++; if (ram_wraddress !== 8'h00) begin miscompares++; $display("FAIL reset ram_wraddress: got %02h, expected 00", ram_wraddress); end
        vectors++; if (ram_rdaddress !== 8'h00) begin miscompares++; $display("FAIL reset ram_rdaddress: got %02h, expected 00", ram_rdaddress); end
        vectors++; if ({ovf_err, unf_err} !== 2'b00) begin miscompares++; $display("FAIL reset err flags: got %b, expected 00", {ovf_err, unf_err}); end
    endtask

    task automatic test_basic();
        do_reset();
        for (int i = 0; i < 16; i++) begin
            wr_req = 1'b1; wr_data = 8'(255 - i);
            tick();
            exp_q.push_back(8'(255 - i));
            if (i == 0) begin
                vectors++; if ({ram_wren, ram_data, ram_wraddress} !== {1'b1, 8'hFF, 8'h00}) begin
                    miscompares++; $display("FAIL first write port: got %b/%02h/%02h, expected 1/ff/00", ram_wren, ram_data, ram_wraddress); end
                vectors++; if (usedw !== 9'd1) begin miscompares++; $display("FAIL first write usedw: got %0d, expected 1", usedw); end
                vectors++; if (empty !== 1'b1) begin miscompares++; $display("FAIL empty one clock after write: got %b, expected 1", empty); end
            end
            if (i == 1) begin
                vectors++; if (empty !== 1'b0) begin miscompares++; $display("FAIL empty two clocks after write: got %b, expected 0", empty); end
            end
        end
        wr_req = 1'b0;
        repeat (20) tick();
        vectors++; if (usedw !== 9'd16) begin miscompares++; $display("FAIL basic usedw before reads: got %0d, expected 16", usedw); end
        rd_req = 1'b1;
        repeat (16) tick();
        rd_req = 1'b0;
        repeat (4) tick();
        check_stream("basic");
        vectors++; if ({empty, usedw} !== {1'b1, 9'd0}) begin miscompares++; $display("FAIL basic end state: got empty=%b usedw=%0d, expected 1/0", empty, usedw); end
    endtask

    task automatic test_full();
        do_reset();
        for (int i = 0; i < 256; i++) begin
            wr_req = 1'b1; wr_data = 8'(i);
            tick();
            exp_q.push_back(8'(i));
        end
        vectors++; if ({full, usedw} !== {1'b1, 9'd256}) begin miscompares++; $display("FAIL full after 256: got full=%b usedw=%0d, expected 1/256", full, usedw); end
        vectors++; if (ram_wraddress !== 8'hFF) begin miscompares++; $display("FAIL last write address: got %02h, expected ff", ram_wraddress); end
        wr_data = 8'hEE;
        tick();  // 257th request, must be refused
        wr_req = 1'b0;
        vectors++; if ({ram_wren, usedw} !== {1'b0, 9'd256}) begin miscompares++; $display("FAIL write while full: got wren=%b usedw=%0d, expected 0/256", ram_wren, usedw); end
        vectors++; if (ovf_err !== ERR_EXP) begin miscompares++; $display("FAIL ovf_err: got %b, expected %b", ovf_err, ERR_EXP); end
        wr_req = 1'b1; rd_req = 1'b1; wr_data = 8'hDD;
        tick();  // both at full: read wins, write refused
        wr_req = 1'b0;
        vectors++; if ({ram_wren, full, usedw} !== {1'b0, 1'b0, 9'd255}) begin
            miscompares++; $display("FAIL rd+wr at full: got wren=%b full=%b usedw=%0d, expected 0/0/255", ram_wren, full, usedw); end
        repeat (255) tick();
        rd_req = 1'b0;
        repeat (4) tick();
        check_stream("full");
        vectors++; if ({empty, usedw} !== {1'b1, 9'd0}) begin miscompares++; $display("FAIL full drain end: got empty=%b usedw=%0d, expected 1/0", empty, usedw); end
    endtask

    task automatic test_underflow();
        do_reset();
        rd_req = 1'b1;
        repeat (3) tick();
        rd_req = 1'b0;
        repeat (3) tick();
        vectors++; if (got.size() !== 0) begin miscompares++; $display("FAIL read on empty pulses: got %0d, expected 0", got.size()); end
        vectors++; if (usedw !== 9'd0) begin miscompares++; $display("FAIL read on empty usedw: got %0d, expected 0", usedw); end
        vectors++; if (unf_err !== ERR_EXP) begin miscompares++; $display("FAIL unf_err: got %b, expected %b", unf_err, ERR_EXP); end
        wr_req = 1'b1; rd_req = 1'b1; wr_data = 8'h3C;
        tick();  // empty: write accepts, read refused
        wr_req = 1'b0; rd_req = 1'b0;
        vectors++; if ({ram_wren, usedw} !== {1'b1, 9'd1}) begin miscompares++; $display("FAIL rd+wr when empty: got wren=%b usedw=%0d, expected 1/1", ram_wren, usedw); end
        repeat (3) tick();
        vectors++; if (got.size() !== 0) begin miscompares++; $display("FAIL rd+wr when empty pulses: got %0d, expected 0", got.size()); end
    endtask

    task automatic test_wrap();
        do_reset();
        for (int i = 0; i < 200; i++) begin
            wr_req = 1'b1; wr_data = 8'(i); tick();
            exp_q.push_back(8'(i));
        end
        wr_req = 1'b0; tick(); tick();
        rd_req = 1'b1; repeat (200) tick(); rd_req = 1'b0;
        repeat (4) tick();
        for (int k = 0; k < 100; k++) begin
            wr_req = 1'b1; wr_data = 8'(8'hA0 + k); tick();
            exp_q.push_back(8'(8'hA0 + k));
            if (k == 55) begin
                vectors++; if (ram_wraddress !== 8'hFF) begin miscompares++; $display("FAIL wrap addr 255: got %02h, expected ff", ram_wraddress); end
            end
            if (k == 56) begin
                vectors++; if (ram_wraddress !== 8'h00) begin miscompares++; $display("FAIL wrap addr 0: got %02h, expected 00", ram_wraddress); end
            end
        end
        wr_req = 1'b0; tick(); tick();
        rd_req = 1'b1; repeat (100) tick(); rd_req = 1'b0;
        repeat (4) tick();
        check_stream("wrap");
        vectors++; if (usedw !== 9'd0) begin miscompares++; $display("FAIL wrap end usedw: got %0d, expected 0", usedw); end
    endtask

    task automatic test_back_to_back();
        int bad;
        do_reset();
        for (int i = 0; i < 10; i++) begin
            wr_req = 1'b1; wr_data = 8'(8'h10 + i); tick();
            exp_q.push_back(8'(8'h10 + i));
        end
        wr_req = 1'b0; repeat (3) tick();
        bad = 0;
        for (int j = 0; j < 50; j++) begin
            wr_req = 1'b1; rd_req = 1'b1; wr_data = 8'(8'h40 + j); tick();
            if (j < 40) exp_q.push_back(8'(8'h40 + j));
            if (usedw !== 9'd10) bad++;
        end
        wr_req = 1'b0; rd_req = 1'b0;
        repeat (4) tick();
        vectors++; if (bad !== 0) begin miscompares++; $display("FAIL b2b usedw: %0d cycles off 10, expected 0", bad); end
        check_stream("b2b");
    endtask

    task automatic test_reset_mid_read();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            wr_req = 1'b1; wr_data = 8'(8'h70 + i); tick();
        end
        wr_req = 1'b0; repeat (3) tick();
        rd_req = 1'b1; tick();      // read accepted, in flight
        rst_n = 1'b0; tick();       // reset before it returns
        rst_n = 1'b1; rd_req = 1'b0;
        repeat (5) tick();
        vectors++; if (got.size() !== 0) begin miscompares++; $display("FAIL rd_valid after reset: got %0d pulses, expected 0", got.size()); end
        vectors++; if ({empty, usedw} !== {1'b1, 9'd0}) begin miscompares++; $display("FAIL state after mid reset: got empty=%b usedw=%0d, expected 1/0", empty, usedw); end
        wr_req = 1'b1; wr_data = 8'h5A; tick();
        wr_req = 1'b0; repeat (3) tick();
        rd_req = 1'b1; tick(); rd_req = 1'b0;
        repeat (4) tick();
        exp_q.push_back(8'h5A);
        check_stream("post_reset");
    endtask

    initial begin
        rst_n = 1'b0; wr_req = 1'b0; rd_req = 1'b0; wr_data = 8'h00;
        test_reset();
        test_basic();
        test_full();
        test_underflow();
        test_wrap();
        test_back_to_back();
        test_reset_mid_read();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
